mmio_fifo_bank: RTL and testbench
=================================

MMIO_FIFO_BANK -- requirements
Module: mmio_fifo_bank

Interface
REQ-001 Parameter NUM_CHANNELS, default 2: number of independent FIFO channels, range 1..8.
REQ-002 Parameter DATA_WIDTH, default 32: entry width in bits.
REQ-003 Parameter ADDR_WIDTH, default 9: each channel holds DEPTH = 2**ADDR_WIDTH entries (512).
REQ-004 Parameter ALMOST_FULL_LEVEL, default 448: almost-full threshold in entries, range 1..DEPTH.
REQ-005 i_clk  in  1: sole clock; all state updates on rising edge.
REQ-006 i_rst  in  1: reset, synchronous, active-high.
REQ-007 i_wr_en  in  NUM_CHANNELS: per-channel push request.
REQ-008 i_wr_data  in  NUM_CHANNELS x DATA_WIDTH: per-channel push data.
REQ-009 i_rd_en  in  NUM_CHANNELS: per-channel pop request.
REQ-010 o_rd_data  out  NUM_CHANNELS x DATA_WIDTH: per-channel head entry, first-word-fall-through.
REQ-011 o_empty, o_full, o_almost_full  out  NUM_CHANNELS each: per-channel status.
REQ-012 o_count  out  NUM_CHANNELS x (ADDR_WIDTH+1): per-channel occupancy, 0..DEPTH.
REQ-013 o_overflow, o_underflow  out  NUM_CHANNELS each: sticky error flags.
REQ-014 i_clear_flags  in  NUM_CHANNELS: per-channel clear of both sticky flags.
REQ-015 i_irq_mask  in  NUM_CHANNELS: 1 = channel contributes to o_irq.
REQ-016 o_irq  out  1: registered interrupt request.

Function
REQ-017 Channels SHALL be fully independent; no event on channel k affects any other channel's state.
REQ-018 Storage SHALL be distributed RAM, written synchronously, read asynchronously at the read pointer.
REQ-019 o_rd_data[k] SHALL equal the oldest stored entry whenever o_empty[k]=0; value is don't-care when empty.
REQ-020 Push accepted when i_wr_en=1 and (count<DEPTH or an accepted pop occurs in the same cycle): data written at write pointer, pointer +1.
REQ-021 Pop accepted when i_rd_en=1 and count>0: read pointer +1; popped data is the o_rd_data value of that cycle.
REQ-022 Pointers SHALL wrap modulo DEPTH (DEPTH-1 -> 0) with no loss or duplication of data.
REQ-023 count next = count + accepted push - accepted pop; simultaneous accepted push and pop leaves count unchanged.
REQ-024 Full and push-with-pop: both accepted, count stays DEPTH, o_full stays 1.
REQ-025 Empty and push-with-pop: push accepted, pop rejected, count becomes 1, underflow set.
REQ-026 Rejected push (full, no pop): data dropped, memory and pointers unchanged, o_overflow set next cycle.
REQ-027 Rejected pop (empty): pointers unchanged, o_underflow set next cycle.
REQ-028 o_empty = (count==0), o_full = (count==DEPTH), o_almost_full = (count>=ALMOST_FULL_LEVEL); all derived from registered count, no combinational path from i_wr_en/i_rd_en.
REQ-029 i_clear_flags[k]=1 clears both sticky flags next cycle; a new error event in the same cycle wins (flag remains 1).
REQ-030 o_irq registered: o_irq next = OR over k of i_irq_mask[k] & (o_almost_full[k] | o_overflow[k] | o_underflow[k]); level, not pulse.
REQ-031 Status and count outputs SHALL be valid the cycle after the push/pop edge; o_irq lags status by one cycle.

Reset
REQ-032 While i_rst=1: all pointers and counts 0, o_empty=1, o_full=0, o_almost_full=0, o_overflow=0, o_underflow=0, o_irq=0; push/pop requests ignored and flagged no errors.
REQ-033 Reset mid-operation SHALL discard all stored entries; memory contents need not be cleared.
REQ-034 First push SHALL be accepted on the first cycle with i_rst=0.

Verification
REQ-035 Ch0 push 0x11,0x22,0x33 on consecutive cycles -> count 1,2,3; o_rd_data 0x11; three pops return 0x11,0x22,0x33; o_empty=1 after.
REQ-036 Ch1 push 512 entries -> o_almost_full asserts at count 448, o_full at 512; 513th push -> data dropped, o_overflow[1]=1, ch0 unaffected; i_clear_flags[1] -> 0.
REQ-037 Ch0 full, simultaneous push 0xAA and pop -> count stays 512, popped oldest entry, 0xAA read last after draining.
REQ-038 Ch0 empty, simultaneous push 0x5 and pop -> count 1, o_underflow[0]=1, o_rd_data 0x5.
REQ-039 1000 push/pop random traffic across pointer wrap versus scoreboard -> no mismatch; mask=2'b10 with ch0 overflow -> o_irq=0; ch1 almost-full -> o_irq=1 one cycle later.
REQ-040 Assert i_rst with ch0 count 7 -> next cycle count 0, o_empty=1, all flags 0, o_irq 0.

Source files
------------

// File: rtl/mmio_fifo_bank.sv
// Bank of independent first-word-fall-through FIFOs with sticky error flags
// and a maskable, registered interrupt request.
module mmio_fifo_bank #(
  parameter int unsigned NUM_CHANNELS      = 2,
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned ADDR_WIDTH        = 9,
  parameter int unsigned ALMOST_FULL_LEVEL = 448
) (
  input  logic                                     i_clk,
  input  logic                                     i_rst,
  input  logic [NUM_CHANNELS-1:0]                  i_wr_en,
  input  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]  i_wr_data,
  input  logic [NUM_CHANNELS-1:0]                  i_rd_en,
  output logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]  o_rd_data,
  output logic [NUM_CHANNELS-1:0]                  o_empty,
  output logic [NUM_CHANNELS-1:0]                  o_full,
  output logic [NUM_CHANNELS-1:0]                  o_almost_full,
  output logic [NUM_CHANNELS-1:0][ADDR_WIDTH:0]    o_count,
  output logic [NUM_CHANNELS-1:0]                  o_overflow,
  output logic [NUM_CHANNELS-1:0]                  o_underflow,
  input  logic [NUM_CHANNELS-1:0]                  i_clear_flags,
  input  logic [NUM_CHANNELS-1:0]                  i_irq_mask,
  output logic                                     o_irq
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;

  for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_ch
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_nxt;
    logic                  empty_q;
    logic                  full_q;
    logic                  afull_q;
    logic                  ovf_q;
    logic                  unf_q;
    logic                  push;
    logic                  pop;
    logic                  ovf_evt;
    logic                  unf_evt;

    // A pop frees a slot in the same cycle, so a full FIFO still takes a push alongside it.
    always_comb begin
      pop       = i_rd_en[k] && (count != '0);
      push      = i_wr_en[k] && ((count != CW'(DEPTH)) || pop);
      ovf_evt   = i_wr_en[k] && !push;
      unf_evt   = i_rd_en[k] && (count == '0);
      count_nxt = count + CW'(push) - CW'(pop);
    end

    always_ff @(posedge i_clk) begin
      if (push && !i_rst) begin
        mem[wr_ptr] <= i_wr_data[k];
      end
    end

    // Status flags are registered from the next count so they line up with o_count.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count   <= '0;
        empty_q <= 1'b1;
        full_q  <= 1'b0;
        afull_q <= 1'b0;
        ovf_q   <= 1'b0;
        unf_q   <= 1'b0;
      end else begin
        wr_ptr  <= wr_ptr + ADDR_WIDTH'(push);
        rd_ptr  <= rd_ptr + ADDR_WIDTH'(pop);
        count   <= count_nxt;
        empty_q <= (count_nxt == '0);
        full_q  <= (count_nxt == CW'(DEPTH));
        afull_q <= (count_nxt >= CW'(ALMOST_FULL_LEVEL));
        ovf_q   <= (ovf_q && !i_clear_flags[k]) || ovf_evt;
        unf_q   <= (unf_q && !i_clear_flags[k]) || unf_evt;
      end
    end

    assign o_rd_data[k]     = mem[rd_ptr];
    assign o_count[k]       = count;
    assign o_empty[k]       = empty_q;
    assign o_full[k]        = full_q;
    assign o_almost_full[k] = afull_q;
    assign o_overflow[k]    = ovf_q;
    assign o_underflow[k]   = unf_q;
  end

  // Interrupt follows the registered status, so it trails it by one cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_irq <= 1'b0;
    end else begin
      o_irq <= |(i_irq_mask & (o_almost_full | o_overflow | o_underflow));
    end
  end

endmodule

// File: tb/tb_mmio_fifo_bank.sv
// Self-checking bench for mmio_fifo_bank: vector table, directed corner
// sequences and random traffic against a queue-based reference model.
module tb_mmio_fifo_bank;

  localparam int unsigned NCH   = 2;
  localparam int unsigned DEPTH = 512;
  localparam int unsigned AFULL = 448;

  logic                  clk;
  logic                  rst;
  logic [NCH-1:0]        wr_en;
  logic [NCH-1:0][31:0]  wr_data;
  logic [NCH-1:0]        rd_en;
  logic [NCH-1:0][31:0]  rd_data;
  logic [NCH-1:0]        empty;
  logic [NCH-1:0]        full;
  logic [NCH-1:0]        afull;
  logic [NCH-1:0][9:0]   count;
  logic [NCH-1:0]        ovf;
  logic [NCH-1:0]        unf;
  logic [NCH-1:0]        clear_flags;
  logic [NCH-1:0]        irq_mask;
  logic                  irq;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] mq [NCH][$];
  bit          m_ovf [NCH];
  bit          m_unf [NCH];
  bit          m_irq;

  mmio_fifo_bank #(
    .NUM_CHANNELS(NCH), .DATA_WIDTH(32), .ADDR_WIDTH(9), .ALMOST_FULL_LEVEL(AFULL)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_wr_data(wr_data), .i_rd_en(rd_en),
    .o_rd_data(rd_data), .o_empty(empty), .o_full(full), .o_almost_full(afull),
    .o_count(count), .o_overflow(ovf), .o_underflow(unf),
    .i_clear_flags(clear_flags), .i_irq_mask(irq_mask), .o_irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: one clock of FIFO behaviour from the current inputs.
  task automatic model_step();
    bit irq_n;
    irq_n = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (irq_mask[k] && (mq[k].size() >= AFULL || m_ovf[k] || m_unf[k])) irq_n = 1'b1;
    end
    if (rst) begin
      for (int k = 0; k < NCH; k++) begin
        mq[k].delete();
        m_ovf[k] = 1'b0;
        m_unf[k] = 1'b0;
      end
      m_irq = 1'b0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        int sz;
        bit popok, pushok;
        sz     = mq[k].size();
        popok  = rd_en[k] && sz > 0;
        pushok = wr_en[k] && (sz < DEPTH || popok);
        if (popok) void'(mq[k].pop_front());
        if (pushok) mq[k].push_back(wr_data[k]);
        m_ovf[k] = (m_ovf[k] && !clear_flags[k]) || (wr_en[k] && !pushok);
        m_unf[k] = (m_unf[k] && !clear_flags[k]) || (rd_en[k] && sz == 0);
      end
      m_irq = irq_n;
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < NCH; k++) begin
      chk($sformatf("count%0d", k), 64'(count[k]), 64'(mq[k].size()));
      chk($sformatf("empty%0d", k), 64'(empty[k]), 64'(mq[k].size() == 0));
      chk($sformatf("full%0d", k), 64'(full[k]), 64'(mq[k].size() == DEPTH));
      chk($sformatf("afull%0d", k), 64'(afull[k]), 64'(mq[k].size() >= AFULL));
      chk($sformatf("ovf%0d", k), 64'(ovf[k]), 64'(m_ovf[k]));
      chk($sformatf("unf%0d", k), 64'(unf[k]), 64'(m_unf[k]));
      if (mq[k].size() > 0) chk($sformatf("rd_data%0d", k), 64'(rd_data[k]), 64'(mq[k][0]));
    end
    chk("irq", 64'(irq), 64'(m_irq));
  endtask

  task automatic step(input logic [1:0] we, input logic [31:0] wd0, input logic [31:0] wd1,
                      input logic [1:0] re, input logic [1:0] clr, input logic r);
    rst         = r;
    wr_en       = we;
    wr_data[0]  = wd0;
    wr_data[1]  = wd1;
    rd_en       = re;
    clear_flags = clr;
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    step(2'b00, 32'h0, 32'h0, 2'b00, 2'b00, 1'b1);
    step(2'b00, 32'h0, 32'h0, 2'b00, 2'b00, 1'b1);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] wd;
    logic        re;
    int unsigned ecount;
    logic [31:0] erd;
    logic        eempty;
  } vec_t;

  vec_t tbl [6];

  initial begin
    tbl[0] = '{1'b1, 32'h11, 1'b0, 1, 32'h11, 1'b0};
    tbl[1] = '{1'b1, 32'h22, 1'b0, 2, 32'h11, 1'b0};
    tbl[2] = '{1'b1, 32'h33, 1'b0, 3, 32'h11, 1'b0};
    tbl[3] = '{1'b0, 32'h00, 1'b1, 2, 32'h22, 1'b0};
    tbl[4] = '{1'b0, 32'h00, 1'b1, 1, 32'h33, 1'b0};
    tbl[5] = '{1'b0, 32'h00, 1'b1, 0, 32'h00, 1'b1};

    rst = 1'b1; wr_en = '0; rd_en = '0; wr_data = '0; clear_flags = '0; irq_mask = '0;
    m_irq = 1'b0;
    for (int k = 0; k < NCH; k++) begin m_ovf[k] = 1'b0; m_unf[k] = 1'b0; end
    do_reset();

    // Basic ordering on ch0, first push right after reset
    for (int i = 0; i < 6; i++) begin
      step({1'b0, tbl[i].we}, tbl[i].wd, 32'h0, {1'b0, tbl[i].re}, 2'b00, 1'b0);
      chk($sformatf("tbl%0d_count", i), 64'(count[0]), 64'(tbl[i].ecount));
      chk($sformatf("tbl%0d_empty", i), 64'(empty[0]), 64'(tbl[i].eempty));
      if (!tbl[i].eempty) chk($sformatf("tbl%0d_rd", i), 64'(rd_data[0]), 64'(tbl[i].erd));
    end

    // Ch1 fill to full, thresholds, overflow, clear
    do_reset();
    for (int n = 1; n <= DEPTH; n++) begin
      step(2'b10, 32'h0, 32'(n), 2'b00, 2'b00, 1'b0);
      if (n == AFULL - 1) chk("afull_below", 64'(afull[1]), 64'd0);
      if (n == AFULL)     chk("afull_at", 64'(afull[1]), 64'd1);
      if (n == DEPTH - 1) chk("full_below", 64'(full[1]), 64'd0);
      if (n == DEPTH)     chk("full_at", 64'(full[1]), 64'd1);
    end
    step(2'b10, 32'h0, 32'hDEAD, 2'b00, 2'b00, 1'b0);
    chk("ovf1_set", 64'(ovf[1]), 64'd1);
    chk("ovf1_count", 64'(count[1]), 64'd512);
    chk("ovf1_head", 64'(rd_data[1]), 64'd1);
    chk("ch0_untouched", 64'({count[0], ovf[0], unf[0], empty[0]}), 64'({10'd0, 3'b001}));
    step(2'b00, 32'h0, 32'h0, 2'b00, 2'b10, 1'b0);
    chk("ovf1_clear", 64'(ovf[1]), 64'd0);

    // Full ch0, push 0xAA with pop, then drain
    do_reset();
    for (int n = 0; n < DEPTH; n++) step(2'b01, 32'(n + 100), 32'h0, 2'b00, 2'b00, 1'b0);
    chk("full_head", 64'(rd_data[0]), 64'd100);
    step(2'b01, 32'hAA, 32'h0, 2'b01, 2'b00, 1'b0);
    chk("full_pp_count", 64'(count[0]), 64'd512);
    chk("full_pp_full", 64'(full[0]), 64'd1);
    chk("full_pp_head", 64'(rd_data[0]), 64'd101);
    for (int n = 0; n < DEPTH - 1; n++) step(2'b00, 32'h0, 32'h0, 2'b01, 2'b00, 1'b0);
    chk("aa_last", 64'(rd_data[0]), 64'hAA);
    chk("aa_last_count", 64'(count[0]), 64'd1);

    // Empty ch0, push 0x5 with pop
    do_reset();
    step(2'b01, 32'h5, 32'h0, 2'b01, 2'b00, 1'b0);
    chk("ep_count", 64'(count[0]), 64'd1);
    chk("ep_unf", 64'(unf[0]), 64'd1);
    chk("ep_rd", 64'(rd_data[0]), 64'h5);

    // Interrupt masking and one-cycle lag
    do_reset();
    irq_mask = 2'b10;
    for (int n = 0; n <= DEPTH; n++) step(2'b01, 32'(n), 32'h0, 2'b00, 2'b00, 1'b0);
    step(2'b00, 32'h0, 32'h0, 2'b00, 2'b00, 1'b0);
    chk("irq_masked", 64'(irq), 64'd0);
    for (int n = 0; n < AFULL; n++) step(2'b10, 32'h0, 32'(n), 2'b00, 2'b00, 1'b0);
    chk("irq_lag_afull", 64'(afull[1]), 64'd1);
    chk("irq_lag_before", 64'(irq), 64'd0);
    step(2'b00, 32'h0, 32'h0, 2'b00, 2'b00, 1'b0);
    chk("irq_after", 64'(irq), 64'd1);

    // Random traffic across pointer wrap
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      logic [1:0] we, re, clr;
      for (int k = 0; k < NCH; k++) begin
        we[k]  = ($urandom_range(0, 99) < 60);
        re[k]  = ($urandom_range(0, 99) < 50);
        clr[k] = ($urandom_range(0, 99) < 5);
      end
      irq_mask = 2'($urandom_range(0, 3));
      step(we, $urandom, $urandom, re, clr, 1'b0);
    end

    // Reset mid-operation with requests held active
    do_reset();
    irq_mask = 2'b11;
    for (int n = 0; n < 7; n++) step(2'b01, 32'(n), 32'h0, 2'b00, 2'b00, 1'b0);
    step(2'b00, 32'h0, 32'h0, 2'b01, 2'b00, 1'b0);
    step(2'b00, 32'h0, 32'h0, 2'b00, 2'b00, 1'b0);
    step(2'b01, 32'h1234, 32'h0, 2'b00, 2'b00, 1'b0);
    chk("pre_rst_count", 64'(count[0]), 64'd7);
    step(2'b11, 32'h77, 32'h88, 2'b11, 2'b00, 1'b1);
    chk("rst_count", 64'(count[0]), 64'd0);
    chk("rst_empty", 64'(empty[0]), 64'd1);
    chk("rst_flags", 64'({ovf, unf, afull, full}), 64'd0);
    chk("rst_irq", 64'(irq), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
